xgmii_ipg_sched_64: RTL and testbench

Schedules the shared XGMII transmit path between the MAC and an auxiliary message source. Sits directly in front of the 10GBASE-R encoder. Each auxiliary 56-bit message is inserted into the inter-packet gap as a 2-word XGMII mini-frame. The MAC always has priority within a frame. The block pauses the MAC only for the word during which a mini-frame occupies the path.

---
 rtl/xgmii_ipg_sched_64.sv | 170 +++++++++++++++++
 tb/tb_xgmii_ipg_sched_64.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_ipg_sched_64.sv
// XGMII transmit scheduler: inserts 2-word aux mini-frames into the MAC inter-packet gap.
// Optional statistics counters are enabled with `define XGMII_IPG_SCHED_STATS_EN.
module xgmii_ipg_sched_64 #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int MIN_IPG    = 3,
    parameter int AUX_BURST  = 4,
    parameter int HOLDOFF    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] mac_txd,
    input  logic [CTRL_WIDTH-1:0] mac_txc,
    output logic                  mac_pause,
    input  logic [DATA_WIDTH-1:0] aux_data,
    input  logic                  aux_valid,
    output logic                  aux_ready,
    output logic [DATA_WIDTH-1:0] xgmii_txd,
    output logic [CTRL_WIDTH-1:0] xgmii_txc,
    output logic                  mac_collision
`ifdef XGMII_IPG_SCHED_STATS_EN
    ,
    output logic [31:0]           aux_sent_count,
    output logic [15:0]           collision_count
`endif
);

    localparam int BURST_W = $clog2(AUX_BURST + 1);

    localparam logic [DATA_WIDTH-1:0] IDLE_TXD     = 64'h0707070707070707;
    localparam logic [DATA_WIDTH-1:0] AUX_TERM_TXD = 64'h07070707070707FD;
    localparam logic [CTRL_WIDTH-1:0] ALL_CTRL     = 8'hFF;
    localparam logic [3:0]            MIN_IPG_C    = 4'(MIN_IPG);
    localparam logic [BURST_W-1:0]    AUX_BURST_C  = BURST_W'(AUX_BURST);
    localparam logic [7:0]            HOLDOFF_C    = 8'(HOLDOFF);

    typedef enum logic [1:0] {
        S_GAP,
        S_FRAME,
        S_AUX_T
    } state_t;

    state_t               state, state_n;
    logic [3:0]           gap_cnt, gap_n;
    logic [BURST_W-1:0]   burst_cnt, burst_n;
    logic [7:0]           hold_cnt, hold_n;
    logic [DATA_WIDTH-1:0] txd_n;
    logic [CTRL_WIDTH-1:0] txc_n;
    logic                 coll_n;

    logic mac_is_idle;
    logic mac_is_start;
    logic mac_is_term;
    logic grant;
    logic unused_aux_hi;

    assign unused_aux_hi = ^aux_data[63:56];

    assign mac_is_idle  = (mac_txc == ALL_CTRL) && (mac_txd == IDLE_TXD);
    assign mac_is_start = ((mac_txc == 8'h01) && (mac_txd[7:0]   == 8'hFB)) ||
                          ((mac_txc == 8'h1F) && (mac_txd[39:32] == 8'hFB));

    always_comb begin
        mac_is_term = 1'b0;
        for (int i = 0; i < CTRL_WIDTH; i++) begin
            if (mac_txc[i] && (mac_txd[8*i +: 8] == 8'hFD)) begin
                mac_is_term = 1'b1;
            end
        end
    end

    // Gated by rst_n so the handshake is never offered while the block is held in reset.
    assign aux_ready = rst_n && (state == S_GAP) && (gap_cnt >= MIN_IPG_C) &&
                       (hold_cnt == 8'd0) && (burst_cnt < AUX_BURST_C) && mac_is_idle;
    assign mac_pause = (state == S_AUX_T);
    assign grant     = aux_valid && aux_ready;

    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        burst_n = burst_cnt;
        hold_n  = hold_cnt;
        txd_n   = mac_txd;
        txc_n   = mac_txc;
        coll_n  = 1'b0;
        case (state)
            S_GAP: begin
                if (grant) begin
                    txd_n   = {aux_data[55:0], 8'hFB};
                    txc_n   = 8'h01;
                    burst_n = burst_cnt + BURST_W'(1);
                    state_n = S_AUX_T;
                end else if (mac_is_term) begin
                    gap_n = 4'd0;
                end else if (mac_is_start) begin
                    state_n = S_FRAME;
                    burst_n = '0;
                    hold_n  = 8'd0;
                end else if (mac_is_idle) begin
                    if (gap_cnt != 4'hF) begin
                        gap_n = gap_cnt + 4'd1;
                    end
                    // Holdoff expiry re-arms the burst allowance.
                    if (hold_cnt != 8'd0) begin
                        hold_n = hold_cnt - 8'd1;
                        if (hold_cnt == 8'd1) begin
                            burst_n = '0;
                        end
                    end
                end
            end
            S_FRAME: begin
                if (mac_is_term) begin
                    state_n = S_GAP;
                    gap_n   = 4'd0;
                end
            end
            S_AUX_T: begin
                txd_n   = AUX_TERM_TXD;
                txc_n   = ALL_CTRL;
                coll_n  = !mac_is_idle;
                state_n = S_GAP;
                gap_n   = 4'd0;
                if (burst_cnt == AUX_BURST_C) begin
                    hold_n = HOLDOFF_C;
                end
            end
            default: begin
                state_n = S_GAP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_GAP;
            gap_cnt       <= MIN_IPG_C;
            burst_cnt     <= '0;
            hold_cnt      <= 8'd0;
            xgmii_txd     <= IDLE_TXD;
            xgmii_txc     <= ALL_CTRL;
            mac_collision <= 1'b0;
        end else begin
            state         <= state_n;
            gap_cnt       <= gap_n;
            burst_cnt     <= burst_n;
            hold_cnt      <= hold_n;
            xgmii_txd     <= txd_n;
            xgmii_txc     <= txc_n;
            mac_collision <= coll_n;
        end
    end

`ifdef XGMII_IPG_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aux_sent_count  <= 32'd0;
            collision_count <= 16'd0;
        end else begin
            if (grant) begin
                aux_sent_count <= aux_sent_count + 32'd1;
            end
            if (coll_n && (collision_count != 16'hFFFF)) begin
                collision_count <= collision_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xgmii_ipg_sched_64.sv
// Self-checking bench for xgmii_ipg_sched_64: reference model feeds an expected-output queue.
module tb_xgmii_ipg_sched_64;

    localparam int MIN_IPG   = 3;
    localparam int AUX_BURST = 4;
    localparam int HOLDOFF   = 8;

    localparam logic [63:0] IDLE_D     = 64'h0707070707070707;
    localparam logic [63:0] AUX_TERM_D = 64'h07070707070707FD;
    localparam int ST_GAP = 0, ST_FRAME = 1, ST_AUX = 2;

    logic        clk;
    logic        rst_n;
    logic [63:0] mac_txd;
    logic [7:0]  mac_txc;
    logic        mac_pause;
    logic [63:0] aux_data;
    logic        aux_valid;
    logic        aux_ready;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        mac_collision;
`ifdef XGMII_IPG_SCHED_STATS_EN
    logic [31:0] aux_sent_count;
    logic [15:0] collision_count;
`endif

    xgmii_ipg_sched_64 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mac_txd       (mac_txd),
        .mac_txc       (mac_txc),
        .mac_pause     (mac_pause),
        .aux_data      (aux_data),
        .aux_valid     (aux_valid),
        .aux_ready     (aux_ready),
        .xgmii_txd     (xgmii_txd),
        .xgmii_txc     (xgmii_txc),
        .mac_collision (mac_collision)
`ifdef XGMII_IPG_SCHED_STATS_EN
        ,
        .aux_sent_count  (aux_sent_count),
        .collision_count (collision_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] txd;
        logic [7:0]  txc;
        logic        coll;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    int m_state, m_gap, m_burst, m_hold, m_sent, m_ccnt;
    logic        last_ready;
    logic [63:0] last_txd;
    logic [7:0]  last_txc;
    logic        last_coll;
    logic        last_pause;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic bit is_idle(input logic [63:0] d, input logic [7:0] c);
        return (c == 8'hFF) && (d == IDLE_D);
    endfunction

    function automatic bit is_start(input logic [63:0] d, input logic [7:0] c);
        return ((c == 8'h01) && (d[7:0] == 8'hFB)) || ((c == 8'h1F) && (d[39:32] == 8'hFB));
    endfunction

    function automatic bit is_term(input logic [63:0] d, input logic [7:0] c);
        bit t = 0;
        for (int k = 0; k < 8; k++) if (c[k] && (d[8*k +: 8] == 8'hFD)) t = 1;
        return t;
    endfunction

    function automatic bit model_ready(input logic [63:0] d, input logic [7:0] c);
        return (m_state == ST_GAP) && (m_gap >= MIN_IPG) && (m_hold == 0) &&
               (m_burst < AUX_BURST) && is_idle(d, c);
    endfunction

    task automatic model_reset();
        m_state = ST_GAP; m_gap = MIN_IPG; m_burst = 0; m_hold = 0;
        m_sent = 0; m_ccnt = 0;
    endtask

    task automatic model_step(input logic [63:0] d, input logic [7:0] c, input logic v,
                              input logic [63:0] a, output exp_t e);
        e.txd = d; e.txc = c; e.coll = 1'b0;
        if (m_state == ST_GAP) begin
            if (v && model_ready(d, c)) begin
                e.txd = {a[55:0], 8'hFB}; e.txc = 8'h01;
                m_burst++; m_sent++; m_state = ST_AUX;
            end else if (is_term(d, c)) begin
                m_gap = 0;
            end else if (is_start(d, c)) begin
                m_state = ST_FRAME; m_burst = 0; m_hold = 0;
            end else if (is_idle(d, c)) begin
                if (m_gap < 15) m_gap++;
                if (m_hold > 0) begin
                    m_hold--;
                    if (m_hold == 0) m_burst = 0;
                end
            end
        end else if (m_state == ST_FRAME) begin
            if (is_term(d, c)) begin m_state = ST_GAP; m_gap = 0; end
        end else begin
            e.txd = AUX_TERM_D; e.txc = 8'hFF; e.coll = !is_idle(d, c);
            if (e.coll && m_ccnt < 65535) m_ccnt++;
            if (m_burst == AUX_BURST) m_hold = HOLDOFF;
            m_state = ST_GAP; m_gap = 0;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic [63:0] d, input logic [7:0] c, input logic v, input logic [63:0] a);
        exp_t e, got;
        mac_txd = d; mac_txc = c; aux_valid = v; aux_data = a;
        #1;
        checkOutput("aux_ready", aux_ready, model_ready(d, c));
        checkOutput("mac_pause", mac_pause, m_state == ST_AUX);
        last_ready = aux_ready;
        last_pause = mac_pause;
        model_step(d, c, v, a, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checkOutput("xgmii_txd", xgmii_txd, got.txd);
        checkOutput("xgmii_txc", xgmii_txc, got.txc);
        checkOutput("mac_collision", mac_collision, got.coll);
        last_txd = xgmii_txd; last_txc = xgmii_txc; last_coll = mac_collision;
        @(negedge clk);
    endtask

    task automatic idle_cycle(input logic v);
        applyStimulus(IDLE_D, 8'hFF, v, 64'hAA11223344556677);
    endtask

    task automatic rand_word(output logic [63:0] d, output logic [7:0] c);
        int r = $urandom_range(0, 9);
        int k;
        d = IDLE_D; c = 8'hFF;
        case (r)
            5: begin d = 64'hD5555555555555FB; c = 8'h01; end
            6: begin d = {24'hD55555, 8'hFB, 32'h07070707}; c = 8'h1F; end
            7: begin d = {$urandom, $urandom}; c = 8'h00; end
            8: begin
                k = $urandom_range(0, 7);
                d = {$urandom, $urandom}; c = 8'hFF << k;
                for (int j = k; j < 8; j++) d[8*j +: 8] = (j == k) ? 8'hFD : 8'h07;
            end
            9: begin d = {32'h00000000, $urandom} << 8; d[7:0] = 8'h9C; c = 8'h01; end
            default: ;
        endcase
    endtask

    initial begin
        int grants[$];
        int exp_grant[5] = '{0, 5, 10, 15, 25};
        int term_idx;
        logic [63:0] d;
        logic [7:0]  c;

        rst_n = 1'b0; mac_txd = IDLE_D; mac_txc = 8'hFF; aux_valid = 1'b0; aux_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checkOutput("rst_txd", xgmii_txd, IDLE_D);
        checkOutput("rst_txc", xgmii_txc, 8'hFF);
        checkOutput("rst_pause", mac_pause, 1'b0);
        checkOutput("rst_ready", aux_ready, 1'b0);
        checkOutput("rst_coll", mac_collision, 1'b0);
        rst_n = 1'b1;

        // Continuous aux traffic: four mini-frames, holdoff, then grants resume.
        for (int i = 0; i < 30; i++) begin
            idle_cycle(1'b1);
            if (last_ready) grants.push_back(i);
            if (i == 0) begin
                checkOutput("first_start_txd", last_txd, 64'h11223344556677FB);
                checkOutput("first_start_txc", last_txc, 8'h01);
            end
            if (i == 1) checkOutput("first_term_txd", last_txd, AUX_TERM_D);
        end
        checkOutput("grant_count", grants.size(), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            checkOutput("grant_cycle", grants[i], exp_grant[i]);

        aux_valid = 1'b0;
        repeat (4) idle_cycle(1'b0);

        // MAC frame with aux pending; START must win over the pending aux message.
        applyStimulus(64'hD5555555555555FB, 8'h01, 1'b1, 64'h0);
        checkOutput("start_blocks_aux", last_ready, 1'b0);
        checkOutput("start_passthrough", last_txd, 64'hD5555555555555FB);
        for (int i = 0; i < 10; i++) applyStimulus({$urandom, $urandom}, 8'h00, 1'b1, 64'h0);
        applyStimulus({32'h07070707, 8'hFD, 24'hABCDEF}, 8'hF8, 1'b1, 64'h0);
        term_idx = 0;
        for (int i = 1; i <= 4; i++) begin
            idle_cycle(1'b1);
            checkOutput("post_term_ready", last_ready, (i == 4));
        end

        // MAC START during the aux terminate cycle collides.
        applyStimulus(64'hD5555555555555FB, 8'h01, 1'b0, 64'h0);
        checkOutput("coll_pause", last_pause, 1'b1);
        checkOutput("coll_term_txd", last_txd, AUX_TERM_D);
        checkOutput("coll_pulse", last_coll, 1'b1);
        idle_cycle(1'b0);
        checkOutput("coll_one_cycle", last_coll, 1'b0);
        repeat (4) idle_cycle(1'b0);

        // Reset asserted while the mini-frame is in flight.
        idle_cycle(1'b1);
        checkOutput("pre_reset_grant", last_ready, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_txd", xgmii_txd, IDLE_D);
        checkOutput("midrst_txc", xgmii_txc, 8'hFF);
        checkOutput("midrst_pause", mac_pause, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle(1'b1);
        checkOutput("post_reset_ready", last_ready, 1'b1);

        // Mixed random MAC traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            rand_word(d, c);
            applyStimulus(d, c, ($urandom_range(0, 3) != 0), {$urandom, $urandom});
        end
        for (int i = 0; i < 30; i++) idle_cycle(1'b1);

`ifdef XGMII_IPG_SCHED_STATS_EN
        checkOutput("aux_sent_count", aux_sent_count, m_sent);
        checkOutput("collision_count", collision_count, m_ccnt);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
